kim_id_ex_reg_p: RTL

KIM_ID_EX_REG_P -- requirements
Module: kim_id_ex_reg_p

---
 rtl/kim_mips_pkg_p.sv | 43 ++++
 rtl/kim_hazard_detect_p.sv | 40 ++++
 rtl/kim_id_ex_reg_p.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/kim_mips_pkg_p.sv
// ---------------------------------------------------------------------------
// kim_mips_pkg_p
// Shared definitions for the kim MIPS-style pipeline: the width of the
// decoded control bundle, the bit position of each control flag inside it,
// and the ALU operation encodings carried in its low nibble.
//
// Control bundle layout (MSB to LSB):
//   [9] reg_write  [8] mem_to_reg  [7] mem_write  [6] mem_read
//   [5] alu_src    [4] reg_dst     [3:0] alu_op
// ---------------------------------------------------------------------------
package kim_mips_pkg_p;

   localparam int CTRL_W         = 10;
   localparam int CTRL_REG_WRITE = 9;
   localparam int CTRL_MEM_TO_REG = 8;
   localparam int CTRL_MEM_WRITE = 7;
   localparam int CTRL_MEM_READ  = 6;
   localparam int CTRL_ALU_SRC   = 5;
   localparam int CTRL_REG_DST   = 4;
   localparam int CTRL_ALU_OP_LSB = 0;
   localparam int ALU_OP_W       = 4;

   // ALU operation codes as they appear in ctrl[3:0]
   typedef enum logic [ALU_OP_W-1:0] {
      ALU_ADD = 4'h0,
      ALU_SUB = 4'h1,
      ALU_AND = 4'h2,
      ALU_OR  = 4'h3,
      ALU_XOR = 4'h4,
      ALU_NOR = 4'h5,
      ALU_SLT = 4'h6,
      ALU_SLL = 4'h7,
      ALU_SRL = 4'h8,
      ALU_SRA = 4'h9,
      ALU_LUI = 4'hA
   } aluOp_e;

   // True when the control bundle describes a load from memory
   function automatic logic ctrlIsLoad(input logic [CTRL_W-1:0] ctrl);
      return ctrl[CTRL_MEM_READ];
   endfunction

endpackage

// File: rtl/kim_hazard_detect_p.sv
// ---------------------------------------------------------------------------
// kim_hazard_detect_p
// Load-use hazard comparator. Flags the case where the instruction in EX is
// a load whose destination (rt) is a source of the instruction sitting in ID;
// the loaded value is not available in time, so the ID instruction must wait.
//
// Ports:
//   ex_valid_i      EX holds a real instruction
//   ex_mem_read_i   EX instruction is a load
//   ex_rt_addr_i    destination register of the EX load
//   id_valid_i      ID holds a real instruction
//   id_rs_addr_i    first source register of the ID instruction
//   id_rt_addr_i    second source register of the ID instruction
//   ld_use_stall_o  combinational hazard flag
// ---------------------------------------------------------------------------
module kim_hazard_detect_p
   import kim_mips_pkg_p::*;
#(
   parameter int REG_ADDR_WIDTH = 5
) (
   input  logic                      ex_valid_i,
   input  logic                      ex_mem_read_i,
   input  logic [REG_ADDR_WIDTH-1:0] ex_rt_addr_i,
   input  logic                      id_valid_i,
   input  logic [REG_ADDR_WIDTH-1:0] id_rs_addr_i,
   input  logic [REG_ADDR_WIDTH-1:0] id_rt_addr_i,
   output logic                      ld_use_stall_o
);

   logic addrMatch;

   // Register 0 is hardwired to zero, so a load targeting it can never
   // create a real dependency and is excluded from the match.
   always_comb begin
      addrMatch      = (ex_rt_addr_i != '0) &&
                       ((ex_rt_addr_i == id_rs_addr_i) || (ex_rt_addr_i == id_rt_addr_i));
      ld_use_stall_o = ex_valid_i && ex_mem_read_i && id_valid_i && addrMatch;
   end

endmodule

// File: rtl/kim_id_ex_reg_p.sv
// ---------------------------------------------------------------------------
// kim_id_ex_reg_p
// ID/EX pipeline register with flush, stall and load-use bubble insertion.
// Next-state priority on each edge: flush > stall (hold) > load-use bubble
// > normal load. A bubble clears valid, control and all data fields.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   stall_i                 hold every EX register
//   flush_i                 replace the incoming instruction with a bubble
//   id_valid_i, id_*_i      instruction fields from the ID stage
//   ex_valid_o, ex_*_o      registered EX stage fields
//   ld_use_stall_o          combinational: freeze PC and IF/ID this cycle
//   bubble_cnt_o            saturating bubble counter (optional)
//
// Build option: define KIM_ID_EX_BUBBLE_CNT_EN to add bubble_cnt_o.
// ---------------------------------------------------------------------------
module kim_id_ex_reg_p
   import kim_mips_pkg_p::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int REG_ADDR_WIDTH = 5
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      stall_i,
   input  logic                      flush_i,
   input  logic                      id_valid_i,
   input  logic [DATA_WIDTH-1:0]     id_pc_plus4_i,
   input  logic [DATA_WIDTH-1:0]     id_rs_data_i,
   input  logic [DATA_WIDTH-1:0]     id_rt_data_i,
   input  logic [DATA_WIDTH-1:0]     id_imm_ext_i,
   input  logic [REG_ADDR_WIDTH-1:0] id_rs_addr_i,
   input  logic [REG_ADDR_WIDTH-1:0] id_rt_addr_i,
   input  logic [REG_ADDR_WIDTH-1:0] id_rd_addr_i,
   input  logic [CTRL_W-1:0]         id_ctrl_i,
   output logic                      ex_valid_o,
   output logic [DATA_WIDTH-1:0]     ex_pc_plus4_o,
   output logic [DATA_WIDTH-1:0]     ex_rs_data_o,
   output logic [DATA_WIDTH-1:0]     ex_rt_data_o,
   output logic [DATA_WIDTH-1:0]     ex_imm_ext_o,
   output logic [REG_ADDR_WIDTH-1:0] ex_rs_addr_o,
   output logic [REG_ADDR_WIDTH-1:0] ex_rt_addr_o,
   output logic [REG_ADDR_WIDTH-1:0] ex_rd_addr_o,
   output logic [CTRL_W-1:0]         ex_ctrl_o,
   output logic                      ld_use_stall_o
`ifdef KIM_ID_EX_BUBBLE_CNT_EN
   ,
   output logic [15:0]               bubble_cnt_o
`endif
);

   logic                      exValid_q,   exValid_d;
   logic [DATA_WIDTH-1:0]     exPcPlus4_q, exPcPlus4_d;
   logic [DATA_WIDTH-1:0]     exRsData_q,  exRsData_d;
   logic [DATA_WIDTH-1:0]     exRtData_q,  exRtData_d;
   logic [DATA_WIDTH-1:0]     exImmExt_q,  exImmExt_d;
   logic [REG_ADDR_WIDTH-1:0] exRsAddr_q,  exRsAddr_d;
   logic [REG_ADDR_WIDTH-1:0] exRtAddr_q,  exRtAddr_d;
   logic [REG_ADDR_WIDTH-1:0] exRdAddr_q,  exRdAddr_d;
   logic [CTRL_W-1:0]         exCtrl_q,    exCtrl_d;
   logic                      ldUseStall;
   logic                      loadBubble;

   // The comparator looks at the registered EX load, so while stalled it
   // keeps reporting the hazard on the held instruction.
   kim_hazard_detect_p #(
      .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
   ) uHazard (
      .ex_valid_i     (exValid_q),
      .ex_mem_read_i  (ctrlIsLoad(exCtrl_q)),
      .ex_rt_addr_i   (exRtAddr_q),
      .id_valid_i     (id_valid_i),
      .id_rs_addr_i   (id_rs_addr_i),
      .id_rt_addr_i   (id_rt_addr_i),
      .ld_use_stall_o (ldUseStall)
   );

   // Flush beats stall; a load-use bubble only happens when not stalled,
   // because a stall keeps the EX load in place for another cycle.
   assign loadBubble = flush_i || (!stall_i && ldUseStall);

   // Next-state selection: bubble clears everything, a stall keeps the
   // defaults (hold), otherwise the ID fields are captured. Control is
   // zeroed for an invalid ID slot so invalid EX never carries control.
   always_comb begin
      exValid_d   = exValid_q;
      exPcPlus4_d = exPcPlus4_q;
      exRsData_d  = exRsData_q;
      exRtData_d  = exRtData_q;
      exImmExt_d  = exImmExt_q;
      exRsAddr_d  = exRsAddr_q;
      exRtAddr_d  = exRtAddr_q;
      exRdAddr_d  = exRdAddr_q;
      exCtrl_d    = exCtrl_q;
      if (loadBubble) begin
         exValid_d   = 1'b0;
         exPcPlus4_d = '0;
         exRsData_d  = '0;
         exRtData_d  = '0;
         exImmExt_d  = '0;
         exRsAddr_d  = '0;
         exRtAddr_d  = '0;
         exRdAddr_d  = '0;
         exCtrl_d    = '0;
      end else if (!stall_i) begin
         exValid_d   = id_valid_i;
         exPcPlus4_d = id_pc_plus4_i;
         exRsData_d  = id_rs_data_i;
         exRtData_d  = id_rt_data_i;
         exImmExt_d  = id_imm_ext_i;
         exRsAddr_d  = id_rs_addr_i;
         exRtAddr_d  = id_rt_addr_i;
         exRdAddr_d  = id_rd_addr_i;
         exCtrl_d    = id_valid_i ? id_ctrl_i : '0;
      end
   end

   // Pipeline register; reset clears all fields without waiting for a clock.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exValid_q   <= 1'b0;
         exPcPlus4_q <= '0;
         exRsData_q  <= '0;
         exRtData_q  <= '0;
         exImmExt_q  <= '0;
         exRsAddr_q  <= '0;
         exRtAddr_q  <= '0;
         exRdAddr_q  <= '0;
         exCtrl_q    <= '0;
      end else begin
         exValid_q   <= exValid_d;
         exPcPlus4_q <= exPcPlus4_d;
         exRsData_q  <= exRsData_d;
         exRtData_q  <= exRtData_d;
         exImmExt_q  <= exImmExt_d;
         exRsAddr_q  <= exRsAddr_d;
         exRtAddr_q  <= exRtAddr_d;
         exRdAddr_q  <= exRdAddr_d;
         exCtrl_q    <= exCtrl_d;
      end
   end

   assign ex_valid_o     = exValid_q;
   assign ex_pc_plus4_o  = exPcPlus4_q;
   assign ex_rs_data_o   = exRsData_q;
   assign ex_rt_data_o   = exRtData_q;
   assign ex_imm_ext_o   = exImmExt_q;
   assign ex_rs_addr_o   = exRsAddr_q;
   assign ex_rt_addr_o   = exRtAddr_q;
   assign ex_rd_addr_o   = exRdAddr_q;
   assign ex_ctrl_o      = exCtrl_q;
   assign ld_use_stall_o = ldUseStall;

`ifdef KIM_ID_EX_BUBBLE_CNT_EN
   logic [15:0] bubbleCnt_q, bubbleCnt_d;

   // Count every bubble that enters EX (flush or load-use), sticking at
   // the maximum. A plain stall loads no bubble, so the count holds.
   always_comb begin
      bubbleCnt_d = bubbleCnt_q;
      if (loadBubble && (bubbleCnt_q != 16'hFFFF)) begin
         bubbleCnt_d = bubbleCnt_q + 16'd1;
      end
   end

   // Bubble counter register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bubbleCnt_q <= '0;
      end else begin
         bubbleCnt_q <= bubbleCnt_d;
      end
   end

   assign bubble_cnt_o = bubbleCnt_q;
`endif

endmodule
